// File: rtl/dma_host_pkg.sv
// Shared types and constants for the DMA host master.
package dma_host_pkg;

    typedef enum logic [1:0] {
        IO2MEM  = 2'd0,
        MEM2IO  = 2'd1,
        MEM2MEM = 2'd2,
        RSVD    = 2'd3
    } mode_e;

    localparam logic [1:0] REG_MODE = 2'd0;
    localparam logic [1:0] REG_SRC  = 2'd1;
    localparam logic [1:0] REG_DST  = 2'd2;
    localparam logic [1:0] REG_CNT  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL,
        ST_WR_MODE,
        ST_WR_SRC,
        ST_WR_DST,
        ST_WR_CNT,
        ST_RELEASE,
        ST_WAIT_REQ,
        ST_GRANT,
        ST_RECLAIM
    } state_e;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_host_if.sv
// Command and DMA-side bus bundle for the DMA host master.
interface dma_host_if #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int CW  = 8,
    parameter int NCH = 4
);
    import dma_host_pkg::*;

    localparam int CHW = ch_width(NCH);

    logic           cmd_valid;
    logic           cmd_ready;
    logic [CHW-1:0] cmd_ch;
    mode_e          cmd_mode;
    logic [AW-1:0]  cmd_src;
    logic [AW-1:0]  cmd_dst;
    logic [CW-1:0]  cmd_count;

    logic           cs;
    logic [CHW-1:0] ch_sel;
    logic [1:0]     reg_sel;
    logic [DW-1:0]  db_out;
    logic           db_wr;
    logic           hreq;
    logic           hack;
    logic           eop;

    modport master (
        input  cmd_valid, cmd_ch, cmd_mode, cmd_src, cmd_dst, cmd_count,
        output cmd_ready,
        output cs, ch_sel, reg_sel, db_out, db_wr, hack,
        input  hreq, eop
    );

    modport slave (
        output cmd_valid, cmd_ch, cmd_mode, cmd_src, cmd_dst, cmd_count,
        input  cmd_ready,
        input  cs, ch_sel, reg_sel, db_out, db_wr, hack,
        output hreq, eop
    );

endinterface

// File: rtl/dma_host_timer.sv
// GRANT watchdog for the DMA host master; compiled only with DMA_HOST_TIMEOUT_EN.
// Down-counter reloaded per command, decremented on each GRANT cycle, held
// otherwise so pauses do not restart the budget.
`ifdef DMA_HOST_TIMEOUT_EN
module dma_host_timer #(
    parameter int TO_CYCLES = 255
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);
    localparam int            TW   = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD = TW'(TO_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    // Reload on a new command, count down while the DMA owns the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= LOAD;
        else if (i_clear)
            r_cnt <= LOAD;
        else if (i_count_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = i_count_en && (r_cnt == '0);

endmodule
`endif

// File: rtl/dma_host_master.sv
// DMA host master: accepts a command, programs the selected DMA channel
// (mode, src, dst, count), then grants the bus on HREQ until EOP.
// Optional: DMA_HOST_TIMEOUT_EN adds TO_CYCLES GRANT watchdog with err abort.
//
// state       | meaning
// IDLE        | ready for a command
// SEL         | chip select asserted, channel selected
// WR_MODE     | write mode register
// WR_SRC      | write source address
// WR_DST      | write destination address
// WR_CNT      | write word count
// RELEASE     | deselect, bus idle
// WAIT_REQ    | waiting for DMA HREQ (also a paused transfer)
// GRANT       | HACK high, DMA owns the bus
// RECLAIM     | bus taken back, done or err pulse
module dma_host_master
    import dma_host_pkg::*;
#(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int CW  = 8,
    parameter int NCH = 4
`ifdef DMA_HOST_TIMEOUT_EN
    , parameter int TO_CYCLES = 255
`endif
)(
    input  logic      clk,
    input  logic      rst_n,
    dma_host_if.master bus,
    output logic      busy,
    output logic      done,
    output logic      err
);
    localparam int CHW = ch_width(NCH);

    state_e         r_state;
    state_e         w_next;
    logic [CHW-1:0] r_ch;
    logic [1:0]     r_mode;
    logic [AW-1:0]  r_src;
    logic [AW-1:0]  r_dst;
    logic [CW-1:0]  r_count;
    logic           r_rej;
    logic           r_abort;
    logic           w_accept;
    logic           w_expired;

    assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);

`ifdef DMA_HOST_TIMEOUT_EN
    dma_host_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_accept),
        .i_count_en (r_state == ST_GRANT),
        .o_expired  (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // State register; reset drops HACK immediately since HACK decodes GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Capture the command fields only when a command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch    <= '0;
            r_mode  <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_ch    <= bus.cmd_ch;
            r_mode  <= bus.cmd_mode;
            r_src   <= bus.cmd_src;
            r_dst   <= bus.cmd_dst;
            r_count <= bus.cmd_count;
        end
    end

    // Zero-count rejection pulse and timeout-abort flag (valid in RECLAIM).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rej   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_rej   <= w_accept && (bus.cmd_count == '0);
            r_abort <= (r_state == ST_GRANT) && !bus.eop && w_expired;
        end
    end

    // Next-state and Moore bus outputs.
    always_comb begin
        w_next        = r_state;
        bus.cmd_ready = 1'b0;
        bus.cs        = 1'b0;
        bus.ch_sel    = '0;
        bus.reg_sel   = REG_MODE;
        bus.db_out    = '0;
        bus.db_wr     = 1'b0;
        bus.hack      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (w_accept && (bus.cmd_count != '0)) w_next = ST_SEL;
            end
            ST_SEL: begin
                bus.cs     = 1'b1;
                bus.ch_sel = r_ch;
                w_next     = ST_WR_MODE;
            end
            ST_WR_MODE: begin
                bus.cs      = 1'b1;
                bus.ch_sel  = r_ch;
                bus.db_wr   = 1'b1;
                bus.reg_sel = REG_MODE;
                bus.db_out  = DW'(r_mode);
                w_next      = ST_WR_SRC;
            end
            ST_WR_SRC: begin
                bus.cs      = 1'b1;
                bus.ch_sel  = r_ch;
                bus.db_wr   = 1'b1;
                bus.reg_sel = REG_SRC;
                bus.db_out  = DW'(r_src);
                w_next      = ST_WR_DST;
            end
            ST_WR_DST: begin
                bus.cs      = 1'b1;
                bus.ch_sel  = r_ch;
                bus.db_wr   = 1'b1;
                bus.reg_sel = REG_DST;
                bus.db_out  = DW'(r_dst);
                w_next      = ST_WR_CNT;
            end
            ST_WR_CNT: begin
                bus.cs      = 1'b1;
                bus.ch_sel  = r_ch;
                bus.db_wr   = 1'b1;
                bus.reg_sel = REG_CNT;
                bus.db_out  = DW'(r_count);
                w_next      = ST_RELEASE;
            end
            ST_RELEASE:  w_next = ST_WAIT_REQ;
            ST_WAIT_REQ: if (bus.hreq) w_next = ST_GRANT;
            ST_GRANT: begin
                bus.hack = 1'b1;
                if (bus.eop)       w_next = ST_RECLAIM;
                else if (w_expired) w_next = ST_RECLAIM;
                else if (!bus.hreq) w_next = ST_WAIT_REQ;
            end
            ST_RECLAIM:  w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_RECLAIM) && !r_abort;
    assign err  = r_rej || ((r_state == ST_RECLAIM) && r_abort);

endmodule

// File: tb/tb_dma_host_master.sv
// Directed bench for dma_host_master; cycle 0 is the command accept cycle.
module tb_dma_host_master;
    import dma_host_pkg::*;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int CW  = 8;
    localparam int NCH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy, done, err;
    int   checks = 0;
    int   errors = 0;

    dma_host_if #(.DW(DW), .AW(AW), .CW(CW), .NCH(NCH)) bus ();

    dma_host_master #(
        .DW(DW), .AW(AW), .CW(CW), .NCH(NCH)
`ifdef DMA_HOST_TIMEOUT_EN
        , .TO_CYCLES(8)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] ch, input mode_e mode,
                            input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = ch;
        bus.cmd_mode  = mode;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_count = cnt;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        #1 rst_n = 1'b0;
        #10;
        got = {bus.cmd_ready, bus.cs, bus.db_wr, bus.hack, busy, done, err};
        checks++;
        if (got !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctl got %b want %b", got, 7'b1000000);
        end
        checks++;
        if (bus.db_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_db got %h want 00", bus.db_out);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [5:0] e, got;
        logic [7:0] ed;
        send_cmd(2'd2, IO2MEM, 8'd100, 8'd10, 8'd3);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready got %b want 1", bus.cmd_ready);
        end
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            bus.hreq = (c >= 9 && c <= 14);
            bus.eop  = (c == 7 || c == 14);
            // {cs, db_wr, hack, done, err, busy}
            if (c == 1)       e = 6'b100001;
            else if (c <= 5)  e = 6'b110001;
            else if (c <= 9)  e = 6'b000001;
            else if (c <= 14) e = 6'b001001;
            else if (c == 15) e = 6'b000101;
            else              e = 6'b000000;
            got = {bus.cs, bus.db_wr, bus.hack, done, err, busy};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL basic_ctl cyc %0d got %b want %b", c, got, e);
            end
            if (c <= 5) begin
                checks++;
                if (bus.ch_sel !== 2'd2) begin
                    errors++;
                    $display("FAIL basic_ch cyc %0d got %0d want 2", c, bus.ch_sel);
                end
            end
            if (c >= 2 && c <= 5) begin
                case (c)
                    2:       ed = 8'd0;
                    3:       ed = 8'd100;
                    4:       ed = 8'd10;
                    default: ed = 8'd3;
                endcase
                checks++;
                if ({bus.reg_sel, bus.db_out} !== {2'(c - 2), ed}) begin
                    errors++;
                    $display("FAIL basic_wr cyc %0d got reg %0d db %0d want reg %0d db %0d",
                             c, bus.reg_sel, bus.db_out, c - 2, ed);
                end
            end
        end
        bus.hreq = 1'b0;
        bus.eop  = 1'b0;
    endtask

    task automatic test_zero_count();
        logic [4:0] e, got;
        send_cmd(2'd1, MEM2IO, 8'd1, 8'd2, 8'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            // {cs, err, busy, cmd_ready, done}
            e = (c == 1) ? 5'b01010 : 5'b00010;
            got = {bus.cs, err, busy, bus.cmd_ready, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL zero_cnt cyc %0d got %b want %b", c, got, e);
            end
        end
    endtask

    task automatic test_pause();
        logic [3:0] e, got;
        send_cmd(2'd1, MEM2IO, 8'd5, 8'd6, 8'd1);
        for (int c = 1; c <= 15; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            bus.hreq = (c == 7 || c == 8 || c == 11 || c == 12);
            bus.eop  = (c == 13);
            // {hack, done, err, busy}
            if (c <= 7)       e = 4'b0001;
            else if (c <= 9)  e = 4'b1001;
            else if (c <= 11) e = 4'b0001;
            else if (c <= 13) e = 4'b1001;
            else if (c == 14) e = 4'b0101;
            else              e = 4'b0000;
            got = {bus.hack, done, err, busy};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pause cyc %0d got %b want %b", c, got, e);
            end
        end
        bus.hreq = 1'b0;
        bus.eop  = 1'b0;
    endtask

    task automatic test_busy_reject();
        logic [7:0] ed;
        send_cmd(2'd3, MEM2MEM, 8'h20, 8'h30, 8'd7);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c >= 3 && c <= 5) send_cmd(2'd0, IO2MEM, 8'h99, 8'h98, 8'd0);
            else                  bus.cmd_valid = 1'b0;
            bus.hreq = (c == 7);
            bus.eop  = (c == 8);
            if (c >= 2 && c <= 5) begin
                case (c)
                    2:       ed = 8'd2;
                    3:       ed = 8'h20;
                    4:       ed = 8'h30;
                    default: ed = 8'd7;
                endcase
                checks++;
                if ({bus.ch_sel, bus.reg_sel, bus.db_out} !== {2'd3, 2'(c - 2), ed}) begin
                    errors++;
                    $display("FAIL reject_wr cyc %0d got ch %0d reg %0d db %h want ch 3 reg %0d db %h",
                             c, bus.ch_sel, bus.reg_sel, bus.db_out, c - 2, ed);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL reject_ready got %b want 0", bus.cmd_ready);
                end
            end
            if (c == 9) begin
                checks++;
                if ({done, err} !== 2'b10) begin
                    errors++;
                    $display("FAIL reject_done got %b want 10", {done, err});
                end
            end
            if (c == 11) begin
                checks++;
                if ({busy, bus.cs, err} !== 3'b000) begin
                    errors++;
                    $display("FAIL reject_idle got %b want 000", {busy, bus.cs, err});
                end
            end
        end
        bus.hreq = 1'b0;
        bus.eop  = 1'b0;
    endtask

`ifdef DMA_HOST_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] e, got;
        send_cmd(2'd0, IO2MEM, 8'd1, 8'd2, 8'd2);
        for (int c = 1; c <= 17; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            bus.hreq = (c >= 7);
            // {hack, done, err, busy}
            if (c <= 7)       e = 4'b0001;
            else if (c <= 15) e = 4'b1001;
            else if (c == 16) e = 4'b0011;
            else              e = 4'b0000;
            got = {bus.hack, done, err, busy};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout cyc %0d got %b want %b", c, got, e);
            end
        end
        bus.hreq = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_grant();
        logic [3:0] got;
        send_cmd(2'd2, IO2MEM, 8'd1, 8'd1, 8'd1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            bus.hreq = (c >= 7);
        end
        checks++;
        if (bus.hack !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_hack got %b want 1", bus.hack);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.hack, busy, bus.cmd_ready, bus.cs};
        checks++;
        if (got !== 4'b0010) begin
            errors++;
            $display("FAIL rst_async got %b want 0010", got);
        end
        bus.hreq = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        got = {bus.hack, busy, bus.cmd_ready, bus.cs};
        checks++;
        if (got !== 4'b0010) begin
            errors++;
            $display("FAIL rst_after got %b want 0010", got);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = '0;
        bus.cmd_mode  = IO2MEM;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_count = '0;
        bus.hreq      = 1'b0;
        bus.eop       = 1'b0;
        test_reset();
        test_basic();
        test_zero_count();
        test_pause();
        test_busy_reject();
`ifdef DMA_HOST_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
